// File: rtl/stepper_seq.sv
// stepper_seq: relative-move stepper sequencer with full/half-step drive, abort and absolute position.
// Half-step moves are honoured only when STEPPER_HALFSTEP_EN is defined; otherwise every move is full-step.
module stepper_seq #(
   parameter int STEP_DIV = 100000,
   parameter int CNT_W    = 16,
   parameter int POS_W    = 24
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic             half_mode,
   input  logic             abort,
   output logic [3:0]       coil,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] steps_left,
   output logic [POS_W-1:0] position,
   output logic             red,
   output logic             green,
   output logic             blue
);
   // state  | meaning
   // S_IDLE | waiting for a command; coils hold the last pattern
   // S_RUN  | stepping once every STEP_DIV cycles
   // S_FIN  | one-cycle done pulse after completion or abort
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

`ifdef STEPPER_HALFSTEP_EN
   localparam bit HALF_EN = 1'b1;
`else
   localparam bit HALF_EN = 1'b0;
`endif

   localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(STEP_DIV - 1);

   state_t           state, state_nxt;
   logic [2:0]       ph, ph_nxt, ph_step;
   logic [POS_W-1:0] pos_nxt;
   logic [CNT_W-1:0] left_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic             dir_q, dir_nxt;
   logic             half_q, half_nxt;
   logic             red_nxt;

   function automatic logic [3:0] coil_of(input logic [2:0] p);
      logic [3:0] c;
      case (p)
         3'd0:    c = 4'b0001;
         3'd1:    c = 4'b0011;
         3'd2:    c = 4'b0010;
         3'd3:    c = 4'b0110;
         3'd4:    c = 4'b0100;
         3'd5:    c = 4'b1100;
         3'd6:    c = 4'b1000;
         default: c = 4'b1001;
      endcase
      return c;
   endfunction

   assign cmd_ready = (state == S_IDLE);

   always_comb begin
      // an even phase in full-step mode takes a single-unit step to realign onto the two-phase entries
      ph_step   = (half_q || !ph[0]) ? 3'd1 : 3'd2;
      state_nxt = state;
      ph_nxt    = ph;
      pos_nxt   = position;
      left_nxt  = steps_left;
      div_nxt   = div;
      dir_nxt   = dir_q;
      half_nxt  = half_q;
      red_nxt   = red;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               dir_nxt   = cmd_dir;
               half_nxt  = HALF_EN & half_mode;
               left_nxt  = cmd_steps;
               red_nxt   = 1'b0;
               div_nxt   = DIV_LOAD;
               state_nxt = (cmd_steps == '0) ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            if (div == '0) begin
               ph_nxt   = dir_q ? ph + ph_step : ph - ph_step;
               pos_nxt  = dir_q ? position + POS_W'(ph_step) : position - POS_W'(ph_step);
               left_nxt = steps_left - CNT_W'(1);
               div_nxt  = DIV_LOAD;
               if (steps_left == CNT_W'(1)) begin
                  state_nxt = S_FIN;
               end else if (abort) begin
                  state_nxt = S_FIN;
                  red_nxt   = 1'b1;
               end
            end else if (abort) begin
               state_nxt = S_FIN;
               red_nxt   = 1'b1;
               div_nxt   = DIV_LOAD;
            end else begin
               div_nxt = div - DIV_W'(1);
            end
         end
         S_FIN: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state      <= S_IDLE;
         ph         <= 3'd1;
         coil       <= 4'b0011;
         position   <= '0;
         steps_left <= '0;
         div        <= DIV_LOAD;
         dir_q      <= 1'b0;
         half_q     <= 1'b0;
         red        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         green      <= 1'b1;
         blue       <= 1'b0;
      end else begin
         state      <= state_nxt;
         ph         <= ph_nxt;
         coil       <= coil_of(ph_nxt);
         position   <= pos_nxt;
         steps_left <= left_nxt;
         div        <= div_nxt;
         dir_q      <= dir_nxt;
         half_q     <= half_nxt;
         red        <= red_nxt;
         busy       <= (state_nxt == S_RUN);
         done       <= (state_nxt == S_FIN);
         green      <= (state_nxt == S_IDLE);
         blue       <= (state_nxt == S_RUN);
      end
   end

endmodule

// File: tb/tb_stepper_seq.sv
// tb_stepper_seq: directed and randomized checks of stepper_seq against a behavioural move model.
module tb_stepper_seq;
   localparam int D = 4;

`ifdef STEPPER_HALFSTEP_EN
   localparam bit HALF_EN = 1'b1;
`else
   localparam bit HALF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_dir = 1'b0;
   logic [15:0] cmd_steps = '0;
   logic        half_mode = 1'b0;
   logic        abort = 1'b0;
   logic        cmd_ready, busy, done, red, green, blue;
   logic [3:0]  coil;
   logic [15:0] steps_left;
   logic [23:0] position;

   stepper_seq #(.STEP_DIV(D), .CNT_W(16), .POS_W(24)) dut (
      .CLOCK_50(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .half_mode(half_mode), .abort(abort),
      .coil(coil), .busy(busy), .done(done), .steps_left(steps_left), .position(position),
      .red(red), .green(green), .blue(blue)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   logic [3:0] coil_tab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
   logic [3:0] cw_exp [4] = '{4'b0110, 4'b1100, 4'b1001, 4'b0011};

   // model: 0 idle, 1 moving, 2 finishing
   int          m_st = 0;
   int          m_ph = 1;
   logic [23:0] m_pos = '0;
   int          m_left = 0;
   bit          m_dir = 1'b0;
   bit          m_half = 1'b0;
   bit          m_red = 1'b0;
   int          m_t = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      int d;
      if (reset) begin
         m_st = 0; m_ph = 1; m_pos = '0; m_left = 0; m_red = 1'b0;
      end else if (m_st == 0) begin
         if (cmd_valid) begin
            m_dir  = cmd_dir;
            m_half = HALF_EN && half_mode;
            m_left = int'(cmd_steps);
            m_red  = 1'b0;
            m_t    = 0;
            m_st   = (cmd_steps == 0) ? 2 : 1;
         end
      end else if (m_st == 1) begin
         m_t++;
         if (m_t % D == 0) begin
            d = (m_half || (m_ph % 2 == 0)) ? 1 : 2;
            m_ph  = m_dir ? (m_ph + d) % 8 : (m_ph + 8 - d) % 8;
            m_pos = m_dir ? m_pos + 24'(d) : m_pos - 24'(d);
            m_left--;
            if (m_left == 0) m_st = 2;
            else if (abort) begin m_st = 2; m_red = 1'b1; end
         end else if (abort) begin
            m_st = 2; m_red = 1'b1;
         end
      end else begin
         m_st = 0;
      end
   endtask

   task automatic check_all();
      check_eq("coil", 32'(coil), 32'(coil_tab[m_ph]));
      check_eq("position", 32'(position), 32'(m_pos));
      check_eq("steps_left", 32'(steps_left), 32'(m_left));
      check_eq("busy", 32'(busy), 32'(m_st == 1));
      check_eq("done", 32'(done), 32'(m_st == 2));
      check_eq("cmd_ready", 32'(cmd_ready), 32'(m_st == 0));
      check_eq("red", 32'(red), 32'(m_red));
      check_eq("green", 32'(green), 32'(m_st == 0));
      check_eq("blue", 32'(blue), 32'(m_st == 1));
   endtask

   task automatic step_cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic issue(input logic dir, input logic [15:0] steps, input logic half);
      cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = steps; half_mode = half;
      step_cycle();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!cmd_ready && n < budget) begin
         step_cycle();
         n++;
      end
      check_eq("idle_timeout", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      // reset state
      step_cycle();
      step_cycle();
      check_eq("rst_coil", 32'(coil), 32'h3);
      check_eq("rst_position", 32'(position), 32'd0);
      check_eq("rst_steps_left", 32'(steps_left), 32'd0);
      check_eq("rst_ready", 32'(cmd_ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_green", 32'(green), 32'd1);
      check_eq("rst_red", 32'(red), 32'd0);
      reset = 1'b0;
      step_cycle();

      // cw full-step, 4 steps
      issue(1'b1, 16'd4, 1'b0);
      for (int i = 1; i <= 17; i++) begin
         step_cycle();
         if (i % 4 == 0) check_eq("cw4_coil", 32'(coil), 32'(cw_exp[i/4 - 1]));
         if (i == 16) begin
            check_eq("cw4_done", 32'(done), 32'd1);
            check_eq("cw4_position", 32'(position), 32'd8);
         end
         if (i == 17) check_eq("cw4_ready", 32'(cmd_ready), 32'd1);
      end
      wait_idle(20);

      // ccw half-step 3, then half 1 cw and full 2 cw (realignment)
      issue(1'b0, 16'd3, 1'b1);
      wait_idle(40);
      issue(1'b1, 16'd1, 1'b1);
      wait_idle(20);
      issue(1'b1, 16'd2, 1'b0);
      wait_idle(20);

      // zero-step command, then cmd_valid pulses during a move
      issue(1'b0, 16'd0, 1'b0);
      check_eq("zero_done", 32'(done), 32'd1);
      check_eq("zero_busy", 32'(busy), 32'd0);
      step_cycle();
      issue(1'b1, 16'd3, 1'b0);
      for (int i = 0; i < 3*D - 1; i++) begin
         cmd_valid = (i % 2 == 0); cmd_steps = 16'd7; cmd_dir = 1'b0;
         step_cycle();
      end
      cmd_valid = 1'b0;
      wait_idle(20);

      // abort after 2 of 10 steps
      issue(1'b1, 16'd10, 1'b0);
      repeat (2*D) step_cycle();
      abort = 1'b1;
      step_cycle();
      abort = 1'b0;
      check_eq("abort_done", 32'(done), 32'd1);
      check_eq("abort_left", 32'(steps_left), 32'd8);
      check_eq("abort_red", 32'(red), 32'd1);
      repeat (3) step_cycle();
      check_eq("abort_red_hold", 32'(red), 32'd1);
      issue(1'b0, 16'd1, 1'b0);
      check_eq("abort_red_clear", 32'(red), 32'd0);
      wait_idle(20);

      // abort on the last step's edge
      issue(1'b1, 16'd3, 1'b0);
      repeat (3*D - 1) step_cycle();
      abort = 1'b1;
      step_cycle();
      abort = 1'b0;
      check_eq("lastab_done", 32'(done), 32'd1);
      check_eq("lastab_red", 32'(red), 32'd0);
      check_eq("lastab_left", 32'(steps_left), 32'd0);
      wait_idle(20);

      // reset mid-move
      issue(1'b0, 16'd5, 1'b0);
      repeat (D + 2) step_cycle();
      reset = 1'b1;
      step_cycle();
      check_eq("midrst_coil", 32'(coil), 32'h3);
      check_eq("midrst_position", 32'(position), 32'd0);
      check_eq("midrst_busy", 32'(busy), 32'd0);
      check_eq("midrst_ready", 32'(cmd_ready), 32'd1);
      check_eq("midrst_done", 32'(done), 32'd0);
      reset = 1'b0;
      step_cycle();

      // randomized traffic
      repeat (1500) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_dir   = 1'($urandom_range(0, 1));
         cmd_steps = 16'($urandom_range(0, 5));
         half_mode = 1'($urandom_range(0, 1));
         abort     = ($urandom_range(0, 23) == 0);
         reset     = ($urandom_range(0, 299) == 0);
         step_cycle();
      end
      cmd_valid = 1'b0; abort = 1'b0; reset = 1'b0;
      wait_idle(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
